mem_wb_skid: RTL and testbench

Two-entry skid-buffered pipeline register between the MEM and WB stages, the consuming end of the stage-to-stage bus stream that the EX→MEM register produces. It accepts a `{pc_inst, mem_to_wb}` bundle under a valid/allowin handshake, presents it to WB in order, and absorbs one extra beat when WB stalls. Backpressure therefore never depends combinationally on `wb_allowin`. It also provides a synchronous pipeline flush.

---
 rtl/mem_wb_skid.sv | 134 +++++++++++++
 tb/tb_mem_wb_skid.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid.sv
// -----------------------------------------------------------------------------
// mem_wb_skid
//
// Purpose:
//   Two-entry skid-buffered pipeline register between the MEM and WB stages.
//   It accepts a {pc_inst, payload} beat from MEM and presents beats to WB in
//   acceptance order. When WB stalls, it absorbs one extra beat in a skid
//   register. Because of that skid entry, in_allowin is decoded from the
//   registered state only and never depends on wb_allowin in the same cycle.
//   A synchronous flush empties the block and zeroes both entries.
//
// Handshake (both sides use strict valid/ready semantics):
//   A beat moves across an interface on a rising edge where its valid and
//   ready are both high. valid must not wait for ready. Data is sampled only
//   on that edge.
//     input side  : in_valid  / in_allowin  -> accept
//     output side : out_valid / wb_allowin  -> emit
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   flush         in   synchronous flush; drops buffered and same-cycle beats
//   in_valid      in   MEM presents a beat
//   in_allowin    out  block can accept a beat this cycle (state != FULL)
//   pc_inst_ibus  in   incoming PC+instruction   [PC_INST_W-1:0]
//   mem_to_ibus   in   incoming MEM->WB payload  [BUS_W-1:0]
//   out_valid     out  head beat valid for WB (state != EMPTY)
//   wb_allowin    in   WB consumes the head beat this cycle
//   pc_inst_obus  out  head PC+instruction       [PC_INST_W-1:0]
//   to_wb_obus    out  head payload              [BUS_W-1:0]
//   occupancy     out  buffered beat count 0..2; this is also the raw FSM state
// -----------------------------------------------------------------------------
module mem_wb_skid #(
  parameter int PC_INST_W = 64,
  parameter int BUS_W     = 70
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [PC_INST_W-1:0] pc_inst_ibus,
  input  logic [BUS_W-1:0]     mem_to_ibus,
  output logic                 out_valid,
  input  logic                 wb_allowin,
  output logic [PC_INST_W-1:0] pc_inst_obus,
  output logic [BUS_W-1:0]     to_wb_obus,
  output logic [1:0]           occupancy
);

  localparam int ENTRY_W = PC_INST_W + BUS_W;

  // The encoding equals the occupancy, so the occupancy output doubles as the
  // state debug view.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q;
  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] skid_q;

  logic [ENTRY_W-1:0] in_entry;
  logic               accept;
  logic               emit;

  assign in_entry = {pc_inst_ibus, mem_to_ibus};

  // Both handshake outputs are pure decodes of the registered state.
  assign in_allowin = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign occupancy  = state_q;

  assign accept = in_valid & in_allowin;
  assign emit   = out_valid & wb_allowin;

  // The head register drives the output buses directly.
  assign pc_inst_obus = head_q[ENTRY_W-1:BUS_W];
  assign to_wb_obus   = head_q[BUS_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      // A same-cycle accept is dropped. A same-cycle emit was already taken
      // by WB, so nothing needs to be done for it.
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q  <= in_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          case ({accept, emit})
            2'b10: begin
              // WB stalled: park the new beat behind the head.
              skid_q  <= in_entry;
              state_q <= FULL;
            end
            2'b01: begin
              // The head data is left in place. It is simply no longer valid.
              state_q <= EMPTY;
            end
            2'b11: begin
              head_q  <= in_entry;
            end
            default: begin
            end
          endcase
        end
        FULL: begin
          // Accept is impossible here because in_allowin is low.
          if (emit) begin
            head_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_skid.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_skid
//
// Bench for mem_wb_skid. The reference model is a FIFO queue of accepted beats
// with capacity 2. The head shown to WB is the front of that queue. If the
// queue is empty, the head shows the last beat that left, or zero after reset
// or flush.
// -----------------------------------------------------------------------------
module tb_mem_wb_skid;

  localparam int PW = 64;
  localparam int BW = 70;
  localparam int EW = PW + BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_allowin;
  logic [PW-1:0] pc_inst_ibus = '0;
  logic [BW-1:0] mem_to_ibus = '0;
  logic          out_valid;
  logic          wb_allowin = 1'b0;
  logic [PW-1:0] pc_inst_obus;
  logic [BW-1:0] to_wb_obus;
  logic [1:0]    occupancy;

  mem_wb_skid #(.PC_INST_W(PW), .BUS_W(BW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_allowin   (in_allowin),
    .pc_inst_ibus (pc_inst_ibus),
    .mem_to_ibus  (mem_to_ibus),
    .out_valid    (out_valid),
    .wb_allowin   (wb_allowin),
    .pc_inst_obus (pc_inst_obus),
    .to_wb_obus   (to_wb_obus),
    .occupancy    (occupancy)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;

  logic [EW-1:0] exp_q[$];          // accepted, not yet emitted beats
  logic [EW-1:0] last_head = '0;    // value the head shows when the queue is empty

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_head();
    if (exp_q.size() > 0) return exp_q[0];
    return last_head;
  endfunction

  task automatic check_against_model(input string tag);
    chk({tag, ".out_valid"},  EW'(out_valid),  EW'(exp_q.size() > 0));
    chk({tag, ".in_allowin"}, EW'(in_allowin), EW'(exp_q.size() < 2));
    chk({tag, ".occupancy"},  EW'(occupancy),  EW'(exp_q.size()));
    chk({tag, ".head"},       {pc_inst_obus, to_wb_obus}, model_head());
  endtask

  function automatic void model_reset();
    exp_q.delete();
    last_head = '0;
  endfunction

  // ---------------- driver ----------------
  // This task drives one cycle. It first checks that in_allowin ignores
  // wb_allowin. Then it advances the model on the edge and compares the
  // outputs to the model.
  task automatic step(input logic fl, input logic iv, input logic wa,
                      input logic [PW-1:0] pc, input logic [BW-1:0] bus);
    logic a0;
    logic acc;
    logic em;
    @(negedge clk);
    flush = fl; in_valid = iv; wb_allowin = wa;
    pc_inst_ibus = pc; mem_to_ibus = bus;
    #1;
    a0 = in_allowin;
    wb_allowin = ~wa;
    #1;
    chk("allowin_vs_wb_allowin", EW'(in_allowin), EW'(a0));
    wb_allowin = wa;
    #1;
    chk("pre_edge.in_allowin", EW'(in_allowin), EW'(exp_q.size() < 2));
    @(posedge clk);
    acc = iv && (exp_q.size() < 2);
    em  = wa && (exp_q.size() > 0);
    if (fl) begin
      model_reset();
    end else begin
      if (em) last_head = exp_q.pop_front();
      if (acc) exp_q.push_back({pc, bus});
    end
    #1;
    check_against_model("model");
  endtask

  function automatic logic [PW-1:0] pc_of(input int t);
    return (t == 0) ? '0 : (64'h1000_0000_0000_0000 | PW'(t));
  endfunction

  function automatic logic [BW-1:0] bus_of(input int t);
    return (t == 0) ? '0 : (70'h2A_0000_0000_0000_0000 | BW'(t * 3));
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic fl;
    logic iv;
    logic wa;
    int   in_tag;
    logic e_ov;
    logic e_ia;
    int   e_occ;
    int   e_tag;   // expected head tag (0 = all-zero head)
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic iv, input logic wa, input int it,
                              input logic ov, input logic ia, input int occ, input int et);
    vec_t v;
    v.fl = fl; v.iv = iv; v.wa = wa; v.in_tag = it;
    v.e_ov = ov; v.e_ia = ia; v.e_occ = occ; v.e_tag = et;
    return v;
  endfunction

  initial begin
    // Streaming: eight beats back to back with WB always ready.
    for (int t = 1; t <= 8; t++) vecs.push_back(mk(0, 1, 1, t, 1, 1, 1, t));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 8));    // drain; head data retained
    // Stall fill: A=9, then B=10 and C=11 presented while WB stalls.
    vecs.push_back(mk(0, 1, 0, 9,  1, 1, 1, 9));
    vecs.push_back(mk(0, 1, 0, 10, 1, 0, 2, 9));   // B goes to the skid entry
    vecs.push_back(mk(0, 1, 0, 11, 1, 0, 2, 9));   // C held off
    vecs.push_back(mk(0, 1, 1, 11, 1, 1, 1, 10));  // A out, B to head
    vecs.push_back(mk(0, 1, 1, 11, 1, 1, 1, 11));  // B out, C in
    vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 11));  // C out
    // Simultaneous accept and emit in ONE.
    vecs.push_back(mk(0, 1, 0, 12, 1, 1, 1, 12));
    vecs.push_back(mk(0, 1, 1, 13, 1, 1, 1, 13));
    // Flush while FULL with a same-cycle input beat.
    vecs.push_back(mk(0, 1, 0, 14, 1, 0, 2, 13));
    vecs.push_back(mk(1, 1, 0, 15, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16, 1, 1, 1, 16));
    vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 16));
    // Flush while EMPTY clears the retained head.
    vecs.push_back(mk(1, 1, 1, 17, 0, 1, 0, 0));
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;

    // Reset held low with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flush = 1'($urandom); in_valid = 1'($urandom); wb_allowin = 1'($urandom);
      pc_inst_ibus = {$urandom, $urandom};
      mem_to_ibus = {6'($urandom), $urandom, $urandom};
      @(posedge clk); #1;
      chk("reset.out_valid",  EW'(out_valid),  '0);
      chk("reset.in_allowin", EW'(in_allowin), EW'(1));
      chk("reset.occupancy",  EW'(occupancy),  '0);
      chk("reset.head",       {pc_inst_obus, to_wb_obus}, '0);
    end
    @(negedge clk);
    flush = 0; in_valid = 0; wb_allowin = 0;
    rst_n = 1'b1;
    model_reset();

    // Directed table.
    foreach (vecs[i]) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].wa, pc_of(vecs[i].in_tag), bus_of(vecs[i].in_tag));
      chk($sformatf("vec%0d.out_valid", i),  EW'(out_valid),  EW'(vecs[i].e_ov));
      chk($sformatf("vec%0d.in_allowin", i), EW'(in_allowin), EW'(vecs[i].e_ia));
      chk($sformatf("vec%0d.occupancy", i),  EW'(occupancy),  EW'(vecs[i].e_occ));
      chk($sformatf("vec%0d.head", i), {pc_inst_obus, to_wb_obus},
          {pc_of(vecs[i].e_tag), bus_of(vecs[i].e_tag)});
    end

    // Asynchronous reset mid-cycle while two beats are buffered.
    step(0, 1, 0, pc_of(20), bus_of(20));
    step(0, 1, 0, pc_of(21), bus_of(21));
    @(negedge clk);
    in_valid = 1'b1; wb_allowin = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset.out_valid",  EW'(out_valid),  '0);
    chk("async_reset.in_allowin", EW'(in_allowin), EW'(1));
    chk("async_reset.occupancy",  EW'(occupancy),  '0);
    chk("async_reset.head",       {pc_inst_obus, to_wb_obus}, '0);
    @(negedge clk);
    in_valid = 1'b0; wb_allowin = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0),
           {r0, r1},
           {6'(r2), r1 ^ r2, r0 + r2});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
